mlaccel_memarb: RTL and testbench



---
 rtl/mlaccel_pkg.sv | 22 ++
 rtl/mlaccel_memarb_track.sv | 28 ++
 rtl/mlaccel_memarb.sv | 169 ++++++++++++++++
 tb/tb_mlaccel_memarb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_pkg.sv
// Shared constants for the accelerator memory subsystem: client indices,
// read latency and the memory port shape used by mlaccel_memory and its arbiter.
package mlaccel_pkg;

    localparam int unsigned MEM_AW     = 16;
    localparam int unsigned MEM_DW     = 64;
    localparam int unsigned MEM_BW     = MEM_DW / 8;

    localparam int unsigned CLI_C      = 0;
    localparam int unsigned CLI_H      = 1;
    localparam int unsigned CLI_S      = 2;
    localparam int unsigned NUM_CLI    = 3;

    localparam int unsigned MEM_RD_LAT = 2;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [MEM_BW-1:0] wen;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mlaccel_memarb_track.sv
// Read-tag shift register for one client: a tag entering at grant time
// emerges as that client's rvalid MEM_RD_LAT cycles later.
module mlaccel_memarb_track
    import mlaccel_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rd_i,
    output logic rvalid_o
);

    logic [MEM_RD_LAT-1:0] tag_q, tag_d;

    always_comb begin
        tag_d = {tag_q[MEM_RD_LAT-2:0], rd_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign rvalid_o = tag_q[MEM_RD_LAT-1];

endmodule

// File: rtl/mlaccel_memarb.sv
// Fixed-latency arbiter for the shared memory port (compute > host > sequencer).
// Define MLACCEL_MEMARB_STARVE_EN to enable starvation boosting of host/sequencer.
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        c_req,
    input  logic [15:0] c_addr,
    input  logic [7:0]  c_wen,
    input  logic [63:0] c_wdata,
    output logic        c_ready,
    output logic        c_rvalid,
    output logic [63:0] c_rdata,

    input  logic        h_req,
    input  logic [15:0] h_addr,
    input  logic [1:0]  h_wen,
    input  logic [15:0] h_wdata,
    output logic        h_ack,
    output logic        h_rvalid,
    output logic [15:0] h_rdata,

    input  logic        s_req,
    input  logic [15:0] s_addr,
    output logic        s_ack,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,

    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wen,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 255) begin : gen_bad_limit
        $error("mlaccel_memarb: STARVE_LIMIT must be in 1..255");
    end

    logic [NUM_CLI-1:0] gnt;
    logic               boost_h, boost_s;

`ifdef MLACCEL_MEMARB_STARVE_EN
    localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

    logic [7:0] starve_h_q, starve_h_d;
    logic [7:0] starve_s_q, starve_s_d;

    // Boost only a client still asking; a dropped request forfeits its credit.
    assign boost_h = h_req && (starve_h_q >= Limit);
    assign boost_s = s_req && (starve_s_q >= Limit);

    always_comb begin
        starve_h_d = starve_h_q;
        starve_s_d = starve_s_q;
        if (!h_req || gnt[CLI_H]) begin
            starve_h_d = '0;
        end else if (starve_h_q < Limit) begin
            starve_h_d = starve_h_q + 8'd1;
        end
        if (!s_req || gnt[CLI_S]) begin
            starve_s_d = '0;
        end else if (starve_s_q < Limit) begin
            starve_s_d = starve_s_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            starve_h_q <= '0;
            starve_s_q <= '0;
        end else begin
            starve_h_q <= starve_h_d;
            starve_s_q <= starve_s_d;
        end
    end
`else
    assign boost_h = 1'b0;
    assign boost_s = 1'b0;
`endif

    always_comb begin
        gnt = '0;
        if (boost_h) begin
            gnt[CLI_H] = 1'b1;
        end else if (boost_s) begin
            gnt[CLI_S] = 1'b1;
        end else if (c_req) begin
            gnt[CLI_C] = 1'b1;
        end else if (h_req) begin
            gnt[CLI_H] = 1'b1;
        end else if (s_req) begin
            gnt[CLI_S] = 1'b1;
        end
        if (!resetn) begin
            gnt = '0;
        end
    end

    // c_ready is an acceptance strobe, so it is held low during reset like the acks.
    assign c_ready = resetn && !boost_h && !boost_s;
    assign h_ack   = gnt[CLI_H];
    assign s_ack   = gnt[CLI_S];

    mem_req_t port_q, port_d;

    always_comb begin
        port_d     = port_q;
        port_d.wen = '0;
        if (gnt[CLI_C]) begin
            port_d.addr  = c_addr;
            port_d.wen   = c_wen;
            port_d.wdata = c_wdata;
        end else if (gnt[CLI_H]) begin
            port_d.addr  = h_addr;
            port_d.wen   = {6'b0, h_wen};
            port_d.wdata = {48'b0, h_wdata};
        end else if (gnt[CLI_S]) begin
            port_d.addr  = s_addr;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            port_q <= '0;
        end else begin
            port_q <= port_d;
        end
    end

    assign mem_addr  = port_q.addr;
    assign mem_wen   = port_q.wen;
    assign mem_wdata = port_q.wdata;

    logic rd_c, rd_h, rd_s;

    assign rd_c = gnt[CLI_C] && (c_wen == '0);
    assign rd_h = gnt[CLI_H] && (h_wen == '0);
    assign rd_s = gnt[CLI_S];

    mlaccel_memarb_track u_track_c (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .rd_i     (rd_c),
        .rvalid_o (c_rvalid)
    );

    mlaccel_memarb_track u_track_h (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .rd_i     (rd_h),
        .rvalid_o (h_rvalid)
    );

    mlaccel_memarb_track u_track_s (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .rd_i     (rd_s),
        .rvalid_o (s_rvalid)
    );

    assign c_rdata = mem_rdata;
    assign h_rdata = mem_rdata[15:0];
    assign s_rdata = mem_rdata[31:0];

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Self-checking bench for mlaccel_memarb; read data is scoreboarded against a shadow
// memory. Starvation scenarios follow MLACCEL_MEMARB_STARVE_EN.
module tb_mlaccel_memarb;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        c_req, c_ready, c_rvalid;
    logic [15:0] c_addr;
    logic [7:0]  c_wen;
    logic [63:0] c_wdata, c_rdata;
    logic        h_req, h_ack, h_rvalid;
    logic [15:0] h_addr, h_wdata, h_rdata;
    logic [1:0]  h_wen;
    logic        s_req, s_ack, s_rvalid;
    logic [15:0] s_addr;
    logic [31:0] s_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wen;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    mlaccel_memarb #(.STARVE_LIMIT(15)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .c_req     (c_req),
        .c_addr    (c_addr),
        .c_wen     (c_wen),
        .c_wdata   (c_wdata),
        .c_ready   (c_ready),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .h_req     (h_req),
        .h_addr    (h_addr),
        .h_wen     (h_wen),
        .h_wdata   (h_wdata),
        .h_ack     (h_ack),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .s_req     (s_req),
        .s_addr    (s_addr),
        .s_ack     (s_ack),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pat(input int a);
        logic [15:0] w;
        w = a[15:0];
        return {16'hC0DE, w, 16'hBEEF ^ w, 16'h5A00 + w};
    endfunction

    // Memory device driven by the DUT port, and the shadow model driven by requester intent.
    logic [63:0] dev    [1024];
    logic [63:0] shadow [1024];

    always @(posedge clock) begin
        mem_rdata <= dev[mem_addr[9:0]];
        for (int b = 0; b < 8; b++) begin
            if (mem_wen[b]) dev[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        int          due;
        logic [63:0] data;
    } sb_ent_t;

    sb_ent_t     sb_q [3][$];
    logic        mon_rv [3];
    logic [63:0] mon_rd [3];
    sb_ent_t     ent;

    always @(negedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) sb_q[i].delete();
        end else begin
            mon_rv = '{c_rvalid, h_rvalid, s_rvalid};
            mon_rd = '{c_rdata, {48'b0, h_rdata}, {32'b0, s_rdata}};
            for (int i = 0; i < 3; i++) begin
                if (sb_q[i].size() > 0 && sb_q[i][0].due == cyc) begin
                    check_eq($sformatf("rvalid_cli%0d", i), 64'(mon_rv[i]), 64'd1);
                    if (mon_rv[i]) check_eq($sformatf("rdata_cli%0d", i), mon_rd[i], sb_q[i][0].data);
                    void'(sb_q[i].pop_front());
                end else if (mon_rv[i]) begin
                    check_eq($sformatf("spurious_rvalid_cli%0d", i), 64'(mon_rv[i]), 64'd0);
                end
            end
            if (c_req && c_ready) begin
                if (c_wen == 8'h00) begin
                    ent.due  = cyc + 2;
                    ent.data = shadow[c_addr[9:0]];
                    sb_q[0].push_back(ent);
                end else begin
                    for (int b = 0; b < 8; b++)
                        if (c_wen[b]) shadow[c_addr[9:0]][8*b +: 8] = c_wdata[8*b +: 8];
                end
            end
            if (h_ack) begin
                if (h_wen == 2'b00) begin
                    ent.due  = cyc + 2;
                    ent.data = {48'b0, shadow[h_addr[9:0]][15:0]};
                    sb_q[1].push_back(ent);
                end else begin
                    for (int b = 0; b < 2; b++)
                        if (h_wen[b]) shadow[h_addr[9:0]][8*b +: 8] = h_wdata[8*b +: 8];
                end
            end
            if (s_ack) begin
                ent.due  = cyc + 2;
                ent.data = {32'b0, shadow[s_addr[9:0]][31:0]};
                sb_q[2].push_back(ent);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        c_req = 1'b0;
        h_req = 1'b0;
        s_req = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int h_at, s_at, n_hack, n_sack, n_dip;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dev[i]    = pat(i);
            shadow[i] = pat(i);
        end
        c_req = 0; c_addr = 0; c_wen = 0; c_wdata = 0;
        h_req = 1; h_addr = 16'h0033; h_wen = 0; h_wdata = 0;
        s_req = 1; s_addr = 16'h0044;

        // Reset state, with requests pending to show acks are suppressed
        repeat (2) step();
        sample();
        check_eq("rst_mem_wen", 64'(mem_wen), 64'h0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'h0);
        check_eq("rst_mem_wdata", mem_wdata, 64'h0);
        check_eq("rst_rvalids", 64'({c_rvalid, h_rvalid, s_rvalid}), 64'h0);
        check_eq("rst_acks", 64'({h_ack, s_ack}), 64'h0);
        step();
        h_req = 0; s_req = 0;
        resetn = 1'b1;
        idle(2);

        // Compute read alone
        c_req = 1; c_addr = 16'h0010; c_wen = 8'h00;
        sample(); check_eq("t1_c_ready", 64'(c_ready), 64'd1);
        step(); c_req = 0;
        sample();
        check_eq("t1_mem_addr", 64'(mem_addr), 64'h0010);
        check_eq("t1_mem_wen", 64'(mem_wen), 64'h00);
        step(); sample(); check_eq("t1_c_rvalid", 64'(c_rvalid), 64'd1);
        idle(3);

        // Host write racing a sequencer read
        h_req = 1; h_addr = 16'h0042; h_wen = 2'b11; h_wdata = 16'h1234;
        s_req = 1; s_addr = 16'h0100;
        sample();
        check_eq("t2_h_ack", 64'(h_ack), 64'd1);
        check_eq("t2_s_ack_lose", 64'(s_ack), 64'd0);
        step(); h_req = 0;
        sample();
        check_eq("t2_s_ack", 64'(s_ack), 64'd1);
        check_eq("t2_mem_wen", 64'(mem_wen), 64'h03);
        check_eq("t2_mem_wdata", mem_wdata, 64'h1234);
        check_eq("t2_mem_addr", 64'(mem_addr), 64'h0042);
        step(); s_req = 0;
        sample();
        check_eq("t2_mem_addr_s", 64'(mem_addr), 64'h0100);
        check_eq("t2_s_rvalid_early", 64'(s_rvalid), 64'd0);
        step(); sample(); check_eq("t2_s_rvalid", 64'(s_rvalid), 64'd1);
        idle(3);

        // Sequencer burst
        for (int i = 0; i < 4; i++) begin
            s_req = 1; s_addr = 16'(i);
            sample(); check_eq($sformatf("t3_s_ack%0d", i), 64'(s_ack), 64'd1);
            step();
        end
        idle(4);

        // Compute partial write, then compute read back alongside a host read
        c_req = 1; c_addr = 16'h0020; c_wen = 8'h0F; c_wdata = 64'h1111_2222_3333_4444;
        sample(); check_eq("t4_c_ready_wr", 64'(c_ready), 64'd1);
        step();
        c_wen = 8'h00;
        h_req = 1; h_addr = 16'h0042; h_wen = 2'b00;
        sample();
        check_eq("t4_h_ack_lose", 64'(h_ack), 64'd0);
        check_eq("t4_mem_wen", 64'(mem_wen), 64'h0F);
        check_eq("t4_mem_wdata", mem_wdata, 64'h1111_2222_3333_4444);
        step(); c_req = 0;
        sample(); check_eq("t4_h_ack", 64'(h_ack), 64'd1);
        step();
        idle(4);

        // Host starvation under continuous compute traffic
        n_hack = 0; h_at = -1; n_dip = 0;
        for (int k = 0; k < 40; k++) begin
            c_req = 1; c_addr = 16'h0200; c_wen = 8'h00;
            h_req = (h_at < 0); h_addr = 16'h0050; h_wen = 2'b00;
            sample();
            if (h_ack) begin
                n_hack++;
                if (h_at < 0) h_at = k;
            end
            if (!c_ready) n_dip++;
`ifdef MLACCEL_MEMARB_STARVE_EN
            if (k == 15) check_eq("t6_c_ready_boost", 64'(c_ready), 64'd0);
`endif
            step();
        end
`ifdef MLACCEL_MEMARB_STARVE_EN
        check_eq("t6_h_ack_cycle", 64'(h_at), 64'd15);
        check_eq("t6_h_ack_count", 64'(n_hack), 64'd1);
        check_eq("t6_c_ready_dips", 64'(n_dip), 64'd1);
`else
        check_eq("t6_h_ack_count", 64'(n_hack), 64'd0);
        check_eq("t6_c_ready_dips", 64'(n_dip), 64'd0);
        c_req = 0;
        sample(); check_eq("t6_h_ack_after", 64'(h_ack), 64'd1);
        step();
`endif
        idle(4);

        // Host and sequencer both starving under compute traffic
        h_at = -1; s_at = -1; n_hack = 0; n_sack = 0; n_dip = 0;
        for (int k = 0; k < 25; k++) begin
            c_req = 1; c_addr = 16'h0201; c_wen = 8'h00;
            h_req = (h_at < 0); h_addr = 16'h0051; h_wen = 2'b00;
            s_req = (s_at < 0); s_addr = 16'h0101;
            sample();
            if (h_ack) begin
                n_hack++;
                if (h_at < 0) h_at = k;
            end
            if (s_ack) begin
                n_sack++;
                if (s_at < 0) s_at = k;
            end
            if (!c_ready) n_dip++;
`ifdef MLACCEL_MEMARB_STARVE_EN
            if (k == 17) check_eq("t7_c_ready_resume", 64'(c_ready), 64'd1);
`endif
            step();
        end
`ifdef MLACCEL_MEMARB_STARVE_EN
        check_eq("t7_h_ack_cycle", 64'(h_at), 64'd15);
        check_eq("t7_s_ack_cycle", 64'(s_at), 64'd16);
        check_eq("t7_c_ready_dips", 64'(n_dip), 64'd2);
`else
        check_eq("t7_h_ack_count", 64'(n_hack), 64'd0);
        check_eq("t7_s_ack_count", 64'(n_sack), 64'd0);
        check_eq("t7_c_ready_dips", 64'(n_dip), 64'd0);
`endif
        idle(4);

        // Reset with a host read in flight
        h_req = 1; h_addr = 16'h0050; h_wen = 2'b00;
        sample(); check_eq("t5_h_ack", 64'(h_ack), 64'd1);
        step();
        h_addr = 16'h0042;
        resetn = 1'b0;
        #1;
        check_eq("t5_mem_addr_rst", 64'(mem_addr), 64'h0);
        check_eq("t5_mem_wen_rst", 64'(mem_wen), 64'h0);
        check_eq("t5_h_ack_rst", 64'(h_ack), 64'd0);
        h_req = 0;
        for (int k = 1; k <= 5; k++) begin
            sample(); check_eq($sformatf("t5_h_rvalid_c%0d", k), 64'(h_rvalid), 64'd0);
            step();
            if (k == 2) resetn = 1'b1;
        end
        h_req = 1; h_addr = 16'h0042; h_wen = 2'b00;
        sample(); check_eq("t5_h_ack_post", 64'(h_ack), 64'd1);
        step(); h_req = 0;
        sample(); check_eq("t5_mem_addr_post", 64'(mem_addr), 64'h0042);
        idle(6);

        for (int i = 0; i < 3; i++)
            check_eq($sformatf("sb_drain_cli%0d", i), 64'(sb_q[i].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
